riscv_lsu: RTL

//   Load/store unit between the core MEM stage and the word-wide data_mem (ce/we/addr/data_i/data_o, no byte enables).

---
 rtl/riscv_lsu.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/riscv_lsu.sv
// Load/store unit: LB/LH/LW/LBU/LHU and SB/SH/SW onto a word-wide memory, sub-word stores by read-modify-write.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned half/word requests error out instead of being force-aligned.
module riscv_lsu #(
    parameter int WORD_ADDR = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_unsigned_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        done_o,
    output logic        err_o,
    output logic [31:0] rdata_o,
    output logic        data_ce_o,
    output logic        data_we_o,
    output logic [31:0] data_addr_o,
    output logic [31:0] data_o,
    input  logic [31:0] data_i
);

    // state | meaning
    // IDLE  | waiting for a request, req_ready_o=1
    // RD    | memory read: load data or the old word for a sub-word store
    // WR    | memory write of full or merged word
    // RESP  | done_o pulse, no memory access
    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    state_t      state;
    logic        op_we;
    logic [1:0]  op_size;
    logic        op_uns;
    logic [1:0]  op_lo;
    logic [15:0] op_wdata;

    logic        req_misalign;
    logic        req_err;
    logic [31:0] req_mem_addr;
    logic [31:0] byte_sh;
    logic [31:0] half_sh;
    logic [31:0] load_val;
    logic [31:0] merged;

`ifdef LSU_MISALIGN_TRAP_EN
    assign req_misalign = (req_size_i == 2'd1 && req_addr_i[0]) ||
                          (req_size_i == 2'd2 && req_addr_i[1:0] != 2'b00);
`else
    assign req_misalign = 1'b0;
`endif

    assign req_err     = (req_size_i == 2'd3) || req_misalign;
    assign req_ready_o = (state == IDLE);

    // The memory only sees whole words, so low address bits never reach it.
    assign req_mem_addr = (WORD_ADDR != 0) ? {2'b00, req_addr_i[31:2]}
                                           : {req_addr_i[31:2], 2'b00};

    always_comb begin
        byte_sh  = data_i >> {op_lo, 3'b000};
        half_sh  = data_i >> {op_lo[1], 4'b0000};
        load_val = data_i;
        case (op_size)
            2'd0: load_val = op_uns ? {24'b0, byte_sh[7:0]}
                                    : {{24{byte_sh[7]}}, byte_sh[7:0]};
            2'd1: load_val = op_uns ? {16'b0, half_sh[15:0]}
                                    : {{16{half_sh[15]}}, half_sh[15:0]};
            default: load_val = data_i;
        endcase
    end

    always_comb begin
        merged = data_i;
        if (op_size == 2'd0) begin
            case (op_lo)
                2'd0: merged[7:0]   = op_wdata[7:0];
                2'd1: merged[15:8]  = op_wdata[7:0];
                2'd2: merged[23:16] = op_wdata[7:0];
                default: merged[31:24] = op_wdata[7:0];
            endcase
        end else begin
            if (op_lo[1]) merged[31:16] = op_wdata;
            else          merged[15:0]  = op_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            op_we       <= 1'b0;
            op_size     <= 2'd0;
            op_uns      <= 1'b0;
            op_lo       <= 2'd0;
            op_wdata    <= 16'd0;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
            rdata_o     <= 32'd0;
            data_ce_o   <= 1'b0;
            data_we_o   <= 1'b0;
            data_addr_o <= 32'd0;
            data_o      <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        op_we    <= req_we_i;
                        op_size  <= req_size_i;
                        op_uns   <= req_unsigned_i;
                        op_lo    <= req_addr_i[1:0];
                        op_wdata <= req_wdata_i[15:0];
                        if (req_err) begin
                            state  <= RESP;
                            done_o <= 1'b1;
                            err_o  <= 1'b1;
                            if (!req_we_i) rdata_o <= 32'd0;
                        end else if (req_we_i && req_size_i == 2'd2) begin
                            state       <= WR;
                            data_ce_o   <= 1'b1;
                            data_we_o   <= 1'b1;
                            data_addr_o <= req_mem_addr;
                            data_o      <= req_wdata_i;
                        end else begin
                            state       <= RD;
                            data_ce_o   <= 1'b1;
                            data_we_o   <= 1'b0;
                            data_addr_o <= req_mem_addr;
                        end
                    end
                end
                RD: begin
                    if (!op_we) begin
                        rdata_o   <= load_val;
                        data_ce_o <= 1'b0;
                        done_o    <= 1'b1;
                        state     <= RESP;
                    end else begin
                        data_o    <= merged;
                        data_we_o <= 1'b1;
                        state     <= WR;
                    end
                end
                WR: begin
                    data_ce_o <= 1'b0;
                    data_we_o <= 1'b0;
                    done_o    <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    done_o <= 1'b0;
                    err_o  <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
